instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter ACK_TIMEOUT, default 4: max cycles from enable assertion until memory controller drops done.
REQ-002 The block SHALL have parameter DONE_TIMEOUT, default 1048575: max cycles from ack until done returns high.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports: clock in 1 system clock; reset_n in 1 async active-low reset.
REQ-004 The block SHALL have the following instruction ports: instr_valid in 1 instruction offered; instr_ready out 1 sequencer can accept; instr_opcode in 3 operation; instr_addr in 17 pixel address; instr_data in 8 write colour.
REQ-005 The block SHALL have the following memory-controller ports: mc_enable out 1 start request; mc_operation out 3 operation code; mc_addr_base out 17 address; mc_color out 8 write colour; mc_done in 1 controller idle/finished; mc_rd_data in 8 read result.
REQ-006 The block SHALL have the following status ports: rd_data out 8 last read value; rd_valid out 1 read-complete pulse; done_pulse out 1 instruction-complete pulse; busy out 1 instruction in flight; current_zoom out 3 zoom level; error_code out 2 00 none/01 illegal opcode/10 zoom range/11 timeout.

Function
REQ-007 Opcodes SHALL be: 000 REFRESH (zoom to 1x, no memory op), 001 RD, 010 WR, 011 NHI (zoom in), 100 PR (zoom in), 101 NH (zoom out), 110 BA (zoom out), and 111 illegal.
REQ-008 Zoom SHALL be encoded as 000 0.25x, 001 0.5x, 010 1x, 011 2x, 100 4x; zoom-in SHALL add 1, zoom-out SHALL subtract 1, and no wrap is permitted.
REQ-009 The FSM SHALL have states IDLE, ISSUE, WAIT_DONE, and RESP.
REQ-010 instr_ready SHALL be 1 only in IDLE, and an instruction SHALL be accepted on instr_valid & instr_ready.
REQ-011 On accept, opcode, addr, and data SHALL be registered, and error_code SHALL be cleared.
REQ-012 Illegal opcode SHALL set error_code=01 and go to RESP with no mc_enable.
REQ-013 A zoom-in at 100 or a zoom-out at 000 SHALL set error_code=10 and go to RESP with no mc_enable.
REQ-014 REFRESH SHALL set current_zoom=010 and go directly to RESP.
REQ-015 Other legal opcodes SHALL go to ISSUE on the cycle after accept.
REQ-016 In ISSUE, mc_enable=1, mc_operation=opcode, and mc_addr_base/mc_color SHALL be driven from the registered values.
REQ-017 ISSUE SHALL hold until mc_done=0 is sampled (ack), then deassert mc_enable on the next cycle and enter WAIT_DONE.
REQ-018 If no ack arrives within ACK_TIMEOUT cycles, the block SHALL set error_code=11, deassert mc_enable, and go to RESP.
REQ-019 WAIT_DONE SHALL exit on the first sampled mc_done=1.
REQ-020 If WAIT_DONE exceeds DONE_TIMEOUT cycles, the block SHALL set error_code=11 and go to RESP.
REQ-021 On WAIT_DONE exit for RD, rd_data SHALL capture mc_rd_data, and rd_valid SHALL pulse 1 cycle.
REQ-022 On WAIT_DONE exit for NHI/PR/NH/BA, current_zoom SHALL update.
REQ-023 current_zoom SHALL be unchanged on error.
REQ-024 RESP SHALL pulse done_pulse for exactly 1 cycle and return to IDLE.
REQ-025 busy SHALL equal (state != IDLE).
REQ-026 mc_operation, mc_addr_base, and mc_color SHALL hold their values outside ISSUE.
REQ-027 error_code SHALL be sticky until the next accept.
REQ-028 instr_valid asserted in non-IDLE states SHALL be ignored, and the instruction SHALL not be lost (ready=0).
REQ-029 Minimum throughput SHALL be one instruction per 3 cycles for REFRESH/errors.

Reset
REQ-030 While reset_n=0, the block SHALL be in state IDLE with instr_ready=1 and the following outputs: mc_enable=0, mc_operation=000, mc_addr_base=0, mc_color=0, rd_data=0, rd_valid=0, done_pulse=0, busy=0, current_zoom=010, error_code=00, and timeout counters=0.
REQ-031 Reset asserted mid-instruction SHALL abort immediately, with no done_pulse, and zoom SHALL return to 010.

Structure
REQ-032 A shared package SHALL hold the opcode constants, zoom encodings, error codes, FSM state encodings, and timeout defaults, and SHALL be reused by the memory controller.
REQ-033 One sub-module SHALL be used: op_watchdog (loadable down-counter with expired flag, shared by ACK and DONE timeouts).

Verification
REQ-034 Bench scenario: reset, then RD addr=0x004B0 with mc_done falling 1 cycle after enable and rising 3 cycles later with mc_rd_data=0xA5 -> rd_data=0xA5, rd_valid and done_pulse each 1 cycle, error_code=00.
REQ-035 Bench scenario: NHI twice then PR from 1x -> current_zoom 011, then 100, then third zoom-in gives error_code=10, no mc_enable, zoom stays 100.
REQ-036 Bench scenario: opcode 111 -> error_code=01, done_pulse 2 cycles after accept, mc_enable never asserted.
REQ-037 Bench scenario: WR with mc_done stuck at 1 -> mc_enable high exactly ACK_TIMEOUT cycles, then error_code=11, zoom unchanged.
REQ-038 Bench scenario: reset_n pulsed low during WAIT_DONE of NH at zoom 011 -> all outputs at reset values, zoom=010, no done_pulse; next instruction accepted normally.
REQ-039 Bench scenario: instr_valid held high through busy -> exactly one accept per completed instruction, ready only in IDLE.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and the memory controller it drives:
// opcodes, zoom levels, error codes, FSM states and timeout defaults.
package instr_sequencer_pkg;

   localparam int OP_W    = 3;
   localparam int ADDR_W  = 17;
   localparam int COLOR_W = 8;
   localparam int ZOOM_W  = 3;
   localparam int ERR_W   = 2;

   localparam int ACK_TIMEOUT_DEFAULT  = 4;
   localparam int DONE_TIMEOUT_DEFAULT = 1048575;

   typedef enum logic [OP_W-1:0] {
      OP_REFRESH = 3'b000,
      OP_RD      = 3'b001,
      OP_WR      = 3'b010,
      OP_NHI     = 3'b011,
      OP_PR      = 3'b100,
      OP_NH      = 3'b101,
      OP_BA      = 3'b110,
      OP_ILLEGAL = 3'b111
   } opcode_e;

   typedef enum logic [ZOOM_W-1:0] {
      ZOOM_0P25X = 3'b000,
      ZOOM_0P5X  = 3'b001,
      ZOOM_1X    = 3'b010,
      ZOOM_2X    = 3'b011,
      ZOOM_4X    = 3'b100
   } zoom_e;

   typedef enum logic [ERR_W-1:0] {
      ERR_NONE    = 2'b00,
      ERR_OPCODE  = 2'b01,
      ERR_ZOOM    = 2'b10,
      ERR_TIMEOUT = 2'b11
   } error_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_DONE,
      ST_RESP
   } state_e;

   function automatic logic is_zoom_in(input opcode_e op);
      return (op == OP_NHI) || (op == OP_PR);
   endfunction

   function automatic logic is_zoom_out(input opcode_e op);
      return (op == OP_NH) || (op == OP_BA);
   endfunction

   // Zoom saturates at both ends: a step past 4x or below 0.25x is rejected, never wrapped.
   function automatic logic zoom_blocked(input opcode_e op, input logic [ZOOM_W-1:0] zoom);
      return (is_zoom_in(op) && (zoom == ZOOM_4X)) || (is_zoom_out(op) && (zoom == ZOOM_0P25X));
   endfunction

   function automatic logic [ZOOM_W-1:0] zoom_step(input opcode_e op, input logic [ZOOM_W-1:0] zoom);
      if (is_zoom_in(op))
         return zoom + ZOOM_W'(1);
      else if (is_zoom_out(op))
         return zoom - ZOOM_W'(1);
      else
         return zoom;
   endfunction

endpackage

// File: rtl/instr_sequencer_op_watchdog.sv
// Loadable down-counter used for both the ack and done timeouts; expired is high at zero.
module op_watchdog #(
   parameter int WIDTH = 20
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             tick,
   output logic             expired
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         count_reg <= '0;
      else if (load)
         count_reg <= load_value;
      else if (tick && !expired)
         count_reg <= count_reg - WIDTH'(1);
   end

   assign expired = (count_reg == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Accepts one display instruction at a time, runs the memory-controller handshake for it,
// tracks the zoom level and reports completion, read data and errors.
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEFAULT,
   parameter int DONE_TIMEOUT = DONE_TIMEOUT_DEFAULT
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [OP_W-1:0]    instr_opcode,
   input  logic [ADDR_W-1:0]  instr_addr,
   input  logic [COLOR_W-1:0] instr_data,
   output logic               mc_enable,
   output logic [OP_W-1:0]    mc_operation,
   output logic [ADDR_W-1:0]  mc_addr_base,
   output logic [COLOR_W-1:0] mc_color,
   input  logic               mc_done,
   input  logic [COLOR_W-1:0] mc_rd_data,
   output logic [COLOR_W-1:0] rd_data,
   output logic               rd_valid,
   output logic               done_pulse,
   output logic               busy,
   output logic [ZOOM_W-1:0]  current_zoom,
   output logic [ERR_W-1:0]   error_code
);

   localparam int MAX_TIMEOUT = (ACK_TIMEOUT > DONE_TIMEOUT) ? ACK_TIMEOUT : DONE_TIMEOUT;
   localparam int CNT_W       = (MAX_TIMEOUT < 2) ? 1 : $clog2(MAX_TIMEOUT + 1);

   // The watchdog reports expiry at zero, so loading N-1 allows exactly N cycles.
   localparam logic [CNT_W-1:0] ACK_LOAD  = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] DONE_LOAD = CNT_W'(DONE_TIMEOUT - 1);

   state_e           state_reg;
   opcode_e          op_reg;
   opcode_e          instr_op;
   logic             accept;
   logic             ack;
   logic             wd_load;
   logic             wd_tick;
   logic             wd_expired;
   logic [CNT_W-1:0] wd_value;

   assign instr_op    = opcode_e'(instr_opcode);
   assign instr_ready = (state_reg == ST_IDLE);
   assign busy        = (state_reg != ST_IDLE);
   assign accept      = instr_valid && instr_ready;
   assign ack         = (state_reg == ST_ISSUE) && !mc_done;

   assign wd_load  = accept || ack;
   assign wd_value = (state_reg == ST_IDLE) ? ACK_LOAD : DONE_LOAD;
   assign wd_tick  = ((state_reg == ST_ISSUE) && mc_done) || ((state_reg == ST_WAIT_DONE) && !mc_done);

   op_watchdog #(
      .WIDTH(CNT_W)
   ) u_watchdog (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (wd_load),
      .load_value (wd_value),
      .tick       (wd_tick),
      .expired    (wd_expired)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= ST_IDLE;
         op_reg       <= OP_REFRESH;
         mc_enable    <= 1'b0;
         mc_operation <= '0;
         mc_addr_base <= '0;
         mc_color     <= '0;
         rd_data      <= '0;
         rd_valid     <= 1'b0;
         done_pulse   <= 1'b0;
         current_zoom <= ZOOM_1X;
         error_code   <= ERR_NONE;
      end else begin
         rd_valid   <= 1'b0;
         done_pulse <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  op_reg     <= instr_op;
                  error_code <= ERR_NONE;
                  if (instr_op == OP_REFRESH) begin
                     current_zoom <= ZOOM_1X;
                     state_reg    <= ST_RESP;
                  end else if (instr_op == OP_ILLEGAL) begin
                     error_code <= ERR_OPCODE;
                     state_reg  <= ST_RESP;
                  end else if (zoom_blocked(instr_op, current_zoom)) begin
                     error_code <= ERR_ZOOM;
                     state_reg  <= ST_RESP;
                  end else begin
                     // Controller-facing fields only move when a request is actually issued.
                     mc_enable    <= 1'b1;
                     mc_operation <= instr_opcode;
                     mc_addr_base <= instr_addr;
                     mc_color     <= instr_data;
                     state_reg    <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (!mc_done) begin
                  mc_enable <= 1'b0;
                  state_reg <= ST_WAIT_DONE;
               end else if (wd_expired) begin
                  mc_enable  <= 1'b0;
                  error_code <= ERR_TIMEOUT;
                  state_reg  <= ST_RESP;
               end
            end
            ST_WAIT_DONE: begin
               if (mc_done) begin
                  if (op_reg == OP_RD) begin
                     rd_data  <= mc_rd_data;
                     rd_valid <= 1'b1;
                  end
                  current_zoom <= zoom_step(op_reg, current_zoom);
                  state_reg    <= ST_RESP;
               end else if (wd_expired) begin
                  error_code <= ERR_TIMEOUT;
                  state_reg  <= ST_RESP;
               end
            end
            ST_RESP: begin
               done_pulse <= 1'b1;
               state_reg  <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed vector table, corner sequences and
// randomized instructions against a behavioural model of the instruction rules.
module tb_instr_sequencer;

   localparam int ACK_TO  = 4;
   localparam int DONE_TO = 16;

   localparam logic [45:0] RESET_VEC = {1'b1, 1'b0, 3'b000, 17'd0, 8'd0, 8'd0,
                                        1'b0, 1'b0, 1'b0, 3'b010, 2'b00};

   logic        clock = 1'b0;
   logic        reset_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [2:0]  instr_opcode;
   logic [16:0] instr_addr;
   logic [7:0]  instr_data;
   logic        mc_enable;
   logic [2:0]  mc_operation;
   logic [16:0] mc_addr_base;
   logic [7:0]  mc_color;
   logic        mc_done;
   logic [7:0]  mc_rd_data;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        done_pulse;
   logic        busy;
   logic [2:0]  current_zoom;
   logic [1:0]  error_code;

   always #5 clock = ~clock;

   instr_sequencer #(
      .ACK_TIMEOUT  (ACK_TO),
      .DONE_TIMEOUT (DONE_TO)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr_opcode (instr_opcode),
      .instr_addr   (instr_addr),
      .instr_data   (instr_data),
      .mc_enable    (mc_enable),
      .mc_operation (mc_operation),
      .mc_addr_base (mc_addr_base),
      .mc_color     (mc_color),
      .mc_done      (mc_done),
      .mc_rd_data   (mc_rd_data),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .done_pulse   (done_pulse),
      .busy         (busy),
      .current_zoom (current_zoom),
      .error_code   (error_code)
   );

   typedef struct {
      logic [2:0]  op;
      logic [16:0] addr;
      logic [7:0]  data;
      int          ack_dly;
      int          busy_len;
      logic [7:0]  rdv;
      logic [1:0]  err;
      logic [2:0]  zoom;
      int          en;
      int          lat;
      int          rdvld;
      logic [7:0]  rd;
   } vec_t;

   typedef struct {
      int         en;
      int         rdv;
      int         lat;
      logic [1:0] err;
      logic [2:0] zoom;
      logic [7:0] rd;
      bit         fields_ok;
      bit         hold_ok;
      bit         ready_ok;
   } obs_t;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state
   int         m_zoom;
   logic [7:0] m_rd;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [45:0] out_vec();
      return {instr_ready, mc_enable, mc_operation, mc_addr_base, mc_color, rd_data,
              rd_valid, done_pulse, busy, current_zoom, error_code};
   endfunction

   // Expected result of one instruction, from the opcode/zoom/timeout rules.
   task automatic ref_step(input logic [2:0] op, input int ack_dly, input int busy_len,
                           input logic [7:0] rdv, output logic [1:0] err, output int en,
                           output int lat, output int rdvld);
      bit zin;
      bit zout;
      zin   = (op == 3'd3) || (op == 3'd4);
      zout  = (op == 3'd5) || (op == 3'd6);
      err   = 2'd0;
      en    = 0;
      lat   = 2;
      rdvld = 0;
      if (op == 3'd7) begin
         err = 2'd1;
      end else if (op == 3'd0) begin
         m_zoom = 2;
      end else if ((zin && m_zoom == 4) || (zout && m_zoom == 0)) begin
         err = 2'd2;
      end else if (ack_dly + 1 > ACK_TO) begin
         en  = ACK_TO;
         err = 2'd3;
         lat = ACK_TO + 2;
      end else begin
         en = ack_dly + 1;
         if (busy_len > DONE_TO) begin
            err = 2'd3;
            lat = en + DONE_TO + 2;
         end else begin
            lat = en + busy_len + 2;
            if (op == 3'd1) begin
               m_rd  = rdv;
               rdvld = 1;
            end
            if (zin) m_zoom = m_zoom + 1;
            if (zout) m_zoom = m_zoom - 1;
         end
      end
   endtask

   // Offers one instruction and plays the memory controller: mc_done drops after the
   // request has been seen for ack_dly+1 cycles and returns after busy_len cycles.
   task automatic run_instr(input logic [2:0] op, input logic [16:0] addr, input logic [7:0] data,
                            input int ack_dly, input int busy_len, input logic [7:0] rdv,
                            output obs_t o);
      int          en_seen  = 0;
      int          busy_cnt = 0;
      int          waited   = 0;
      bit          acked    = 0;
      bit          got_done = 0;
      logic [27:0] prev_mc;
      o = '{default: 0};
      o.fields_ok  = 1;
      o.hold_ok    = 1;
      o.ready_ok   = 1;
      mc_done      = 1'b1;
      instr_opcode = op;
      instr_addr   = addr;
      instr_data   = data;
      instr_valid  = 1'b1;
      while (!instr_ready && waited < 50) begin
         @(negedge clock);
         waited++;
      end
      if (!instr_ready) begin
         chk("accept_timeout", 0, 1);
         instr_valid = 1'b0;
         return;
      end
      prev_mc = {mc_operation, mc_addr_base, mc_color};
      @(negedge clock);
      instr_valid = 1'b0;
      for (int cyc = 1; cyc <= 100 && !got_done; cyc++) begin
         if (instr_ready !== !busy) o.ready_ok = 0;
         if (mc_enable) begin
            o.en++;
            if (mc_operation !== op || mc_addr_base !== addr || mc_color !== data) o.fields_ok = 0;
         end else if ({mc_operation, mc_addr_base, mc_color} !== prev_mc) begin
            o.hold_ok = 0;
         end
         prev_mc = {mc_operation, mc_addr_base, mc_color};
         if (rd_valid) o.rdv++;
         if (done_pulse) begin
            got_done = 1;
            o.lat    = cyc;
            o.err    = error_code;
            o.zoom   = current_zoom;
            o.rd     = rd_data;
         end else begin
            if (mc_enable && !acked) begin
               en_seen++;
               if (en_seen > ack_dly) begin
                  mc_done = 1'b0;
                  acked   = 1;
               end
            end else if (acked && !mc_done) begin
               busy_cnt++;
               if (busy_cnt >= busy_len) begin
                  mc_done    = 1'b1;
                  mc_rd_data = rdv;
               end
            end
            @(negedge clock);
         end
      end
      if (!got_done) chk("done_timeout", 0, 1);
      mc_done = 1'b1;
      $display("instr op=%0d addr=%05h data=%02h ack_dly=%0d busy=%0d -> err=%0d zoom=%0d en=%0d lat=%0d rd=%02h",
               op, addr, data, ack_dly, busy_len, o.err, o.zoom, o.en, o.lat, o.rd);
   endtask

   task automatic check_obs(input string tag, input obs_t o, input logic [1:0] err,
                            input logic [2:0] zoom, input int en, input int lat,
                            input int rdvld, input logic [7:0] rd);
      chk({tag, ".error_code"}, o.err, err);
      chk({tag, ".zoom"}, o.zoom, zoom);
      chk({tag, ".enable_cycles"}, o.en, en);
      chk({tag, ".done_latency"}, o.lat, lat);
      chk({tag, ".rd_valid_pulses"}, o.rdv, rdvld);
      chk({tag, ".rd_data"}, o.rd, rd);
      chk({tag, ".mc_fields"}, o.fields_ok, 1);
      chk({tag, ".mc_hold"}, o.hold_ok, 1);
      chk({tag, ".ready_vs_busy"}, o.ready_ok, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        vecs [14];
      obs_t        o;
      logic [1:0]  e_err;
      int          e_en;
      int          e_lat;
      int          e_rdv;
      int          accepts;
      int          dones;
      int          outst;
      int          bad_ready;
      int          bad_outst;
      bit          seen_done;
      logic [2:0]  r_op;
      logic [16:0] r_addr;
      logic [7:0]  r_data;
      logic [7:0]  r_rdv;
      int          r_ack;
      int          r_busy;

      reset_n      = 1'b0;
      instr_valid  = 1'b0;
      instr_opcode = 3'd0;
      instr_addr   = 17'd0;
      instr_data   = 8'd0;
      mc_done      = 1'b1;
      mc_rd_data   = 8'd0;
      m_zoom       = 2;
      m_rd         = 8'd0;

      repeat (3) @(negedge clock);
      #1;
      chk("reset_outputs", out_vec(), RESET_VEC);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      //          op     addr        data   ack   busy  rdv     err   zoom  en lat rdv rd
      vecs[0]  = '{3'd1, 17'h004B0, 8'h00, 1,    3,    8'hA5, 2'd0, 3'd2, 2, 7,  1, 8'hA5};
      vecs[1]  = '{3'd3, 17'h00100, 8'h11, 0,    1,    8'h00, 2'd0, 3'd3, 1, 4,  0, 8'hA5};
      vecs[2]  = '{3'd3, 17'h00200, 8'h22, 0,    2,    8'h00, 2'd0, 3'd4, 1, 5,  0, 8'hA5};
      vecs[3]  = '{3'd4, 17'h00300, 8'h33, 0,    1,    8'h00, 2'd2, 3'd4, 0, 2,  0, 8'hA5};
      vecs[4]  = '{3'd7, 17'h1FFFF, 8'hFF, 0,    1,    8'h00, 2'd1, 3'd4, 0, 2,  0, 8'hA5};
      vecs[5]  = '{3'd2, 17'h12345, 8'h5A, 1000, 1,    8'h00, 2'd3, 3'd4, 4, 6,  0, 8'hA5};
      vecs[6]  = '{3'd5, 17'h0ABCD, 8'h00, 2,    16,   8'h00, 2'd0, 3'd3, 3, 21, 0, 8'hA5};
      vecs[7]  = '{3'd6, 17'h00001, 8'h00, 0,    1000, 8'h00, 2'd3, 3'd3, 1, 19, 0, 8'hA5};
      vecs[8]  = '{3'd2, 17'h1FFFF, 8'hC3, 3,    1,    8'h00, 2'd0, 3'd3, 4, 7,  0, 8'hA5};
      vecs[9]  = '{3'd0, 17'h00000, 8'h00, 0,    1,    8'h00, 2'd0, 3'd2, 0, 2,  0, 8'hA5};
      vecs[10] = '{3'd6, 17'h00010, 8'h00, 0,    1,    8'h00, 2'd0, 3'd1, 1, 4,  0, 8'hA5};
      vecs[11] = '{3'd5, 17'h00020, 8'h00, 0,    1,    8'h00, 2'd0, 3'd0, 1, 4,  0, 8'hA5};
      vecs[12] = '{3'd6, 17'h00030, 8'h00, 0,    1,    8'h00, 2'd2, 3'd0, 0, 2,  0, 8'hA5};
      vecs[13] = '{3'd1, 17'h00FED, 8'h00, 0,    1,    8'h3C, 2'd0, 3'd0, 1, 4,  1, 8'h3C};

      foreach (vecs[i]) begin
         run_instr(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].ack_dly, vecs[i].busy_len,
                   vecs[i].rdv, o);
         check_obs($sformatf("vec%0d", i), o, vecs[i].err, vecs[i].zoom, vecs[i].en,
                   vecs[i].lat, vecs[i].rdvld, vecs[i].rd);
         ref_step(vecs[i].op, vecs[i].ack_dly, vecs[i].busy_len, vecs[i].rdv,
                  e_err, e_en, e_lat, e_rdv);
      end

      // Error code stays put while idle until the next instruction is accepted.
      run_instr(3'd7, 17'h00000, 8'h00, 0, 1, 8'h00, o);
      ref_step(3'd7, 0, 1, 8'h00, e_err, e_en, e_lat, e_rdv);
      check_obs("illegal_again", o, e_err, 3'(m_zoom), e_en, e_lat, e_rdv, m_rd);
      repeat (3) @(negedge clock);
      chk("err_sticky", error_code, 2'd1);
      chk("idle_no_done", {instr_ready, done_pulse, busy}, 3'b100);

      // instr_valid held high across back-to-back short instructions.
      instr_opcode = 3'd0;
      instr_valid  = 1'b1;
      accepts      = 0;
      dones        = 0;
      outst        = 0;
      bad_ready    = 0;
      bad_outst    = 0;
      for (int c = 0; c < 30; c++) begin
         if (instr_ready !== !busy) bad_ready++;
         if (done_pulse) begin
            dones++;
            outst--;
         end
         if (instr_valid && instr_ready) begin
            accepts++;
            outst++;
            if (outst > 1) bad_outst++;
         end else if (!instr_ready) begin
            instr_opcode = ($urandom_range(0, 1) == 1) ? 3'd7 : 3'd0;
         end
         @(negedge clock);
      end
      instr_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (done_pulse) begin
            dones++;
            outst--;
         end
         @(negedge clock);
      end
      $display("held_valid accepts=%0d dones=%0d", accepts, dones);
      chk("held_ready_only_idle", bad_ready, 0);
      chk("held_one_in_flight", bad_outst, 0);
      chk("held_accept_eq_done", accepts, dones);
      chk("held_throughput", (accepts >= 10) ? 1 : 0, 1);
      m_zoom = 2;

      // Reset during WAIT_DONE of a zoom-out at 2x.
      run_instr(3'd3, 17'h00040, 8'h00, 0, 1, 8'h00, o);
      ref_step(3'd3, 0, 1, 8'h00, e_err, e_en, e_lat, e_rdv);
      check_obs("pre_reset_nhi", o, e_err, 3'(m_zoom), e_en, e_lat, e_rdv, m_rd);
      instr_opcode = 3'd5;
      instr_addr   = 17'h00444;
      instr_data   = 8'h44;
      instr_valid  = 1'b1;
      mc_done      = 1'b1;
      @(negedge clock);
      instr_valid = 1'b0;
      chk("nh_issue_enable", mc_enable, 1);
      mc_done = 1'b0;
      @(negedge clock);
      chk("nh_wait_state", {busy, mc_enable}, 2'b10);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("midreset_outputs", out_vec(), RESET_VEC);
      seen_done = 0;
      repeat (2) begin
         @(negedge clock);
         if (done_pulse) seen_done = 1;
      end
      mc_done = 1'b1;
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clock);
         if (done_pulse) seen_done = 1;
      end
      chk("abort_no_done", seen_done, 0);
      chk("abort_zoom", current_zoom, 3'd2);
      m_zoom = 2;
      m_rd   = 8'd0;
      run_instr(3'd1, 17'h00777, 8'h00, 1, 2, 8'h77, o);
      ref_step(3'd1, 1, 2, 8'h77, e_err, e_en, e_lat, e_rdv);
      check_obs("post_reset_rd", o, e_err, 3'(m_zoom), e_en, e_lat, e_rdv, m_rd);

      // Randomized instructions against the model.
      for (int i = 0; i < 40; i++) begin
         r_op   = 3'($urandom_range(0, 7));
         r_addr = 17'($urandom);
         r_data = 8'($urandom);
         r_rdv  = 8'($urandom);
         r_ack  = int'($urandom_range(0, 5));
         r_busy = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 20)) : int'($urandom_range(1, 4));
         ref_step(r_op, r_ack, r_busy, r_rdv, e_err, e_en, e_lat, e_rdv);
         run_instr(r_op, r_addr, r_data, r_ack, r_busy, r_rdv, o);
         check_obs($sformatf("rand%0d", i), o, e_err, 3'(m_zoom), e_en, e_lat, e_rdv, m_rd);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
